// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one word-wide backing memory port between the instruction-fetch (IF)
// requester and the data (D) requester. D has fixed priority over IF. The
// winning request is registered onto a req/ack backing handshake, and the
// owner gets a one-cycle ready pulse carrying read data and an error flag.
// Misaligned addresses are rejected without a backing access. An access that
// is never acknowledged is aborted after TIMEOUT cycles.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   if_req/if_addr                fetch request (held until if_ready)
//   if_ready/if_rdata/if_err      fetch response (pulse, held data, error)
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ready)
//   d_ready/d_rdata/d_err         data response (pulse, held data, error)
//   m_req/m_we/m_addr/m_wdata     backing request (held until ack or abort)
//   m_ack/m_rdata                 backing completion pulse and read data
//   busy                          arbiter not idle
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ready <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            d_ready  <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // D is the older instruction in the pipeline, so it wins.
                    if (d_req) begin
                        busy <= 1'b1;
                        if (d_addr[1:0] == 2'b00) begin
                            m_req   <= 1'b1;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            count   <= '0;
                            state   <= BUSY_D;
                        end else begin
                            d_ready <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                            state   <= RESP;
                        end
                    end else if (if_req) begin
                        busy <= 1'b1;
                        if (if_addr[1:0] == 2'b00) begin
                            m_req   <= 1'b1;
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            count   <= '0;
                            state   <= BUSY_IF;
                        end else begin
                            if_ready <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                            state    <= RESP;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                BUSY_IF: begin
                    if (m_ack) begin
                        m_req    <= 1'b0;
                        if_ready <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= m_rdata;
                        state    <= RESP;
                    end else if (count == LAST_WAIT) begin
                        m_req    <= 1'b0;
                        if_ready <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                        state    <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        d_err   <= 1'b0;
                        // Stores return zero; the bus read data is meaningless then.
                        d_rdata <= m_we ? '0 : m_rdata;
                        state   <= RESP;
                    end else if (count == LAST_WAIT) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                        state   <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    // Only the owner's ready was set, so clearing both is safe.
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    m_req    <= 1'b0;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard queues per requester, a
// behavioural backing memory with a per-access ack plan, and a negedge monitor.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ready, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    // w >= 0: ack after w wait cycles; w < 0: never ack
    typedef struct {
        int          w;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } plan_t;

    resp_t if_q[$];
    resp_t d_q[$];
    plan_t if_plan[$];
    plan_t d_plan[$];

    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bmem[logic [31:0]];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : seed_word(a);
    endfunction

    // Fetch transaction: predict response, plan the memory, drive, wait.
    task automatic do_if(input logic [31:0] addr, input int w, input bit solo);
        resp_t r;
        plan_t p;
        int    lat;
        int    exp_lat;
        if (addr[1:0] != 2'b00) begin
            r.rdata = 32'h0; r.err = 1'b1; exp_lat = 1;
        end else begin
            p.w = w; p.we = 1'b0; p.addr = addr; p.wdata = 32'h0;
            if_plan.push_back(p);
            r.err   = (w < 0);
            r.rdata = (w < 0) ? 32'h0 : ref_rd(addr);
            exp_lat = (w < 0) ? TO + 1 : w + 2;
        end
        if_q.push_back(r);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (if_ready) break;
            lat++;
        end
        if (lat >= 60) chk("if_ready_timeout", 64'(lat), 64'(exp_lat));
        else if (solo) chk("if_latency", 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // Data transaction: predict response and memory effect, drive, wait.
    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input bit solo);
        resp_t r;
        plan_t p;
        int    lat;
        int    exp_lat;
        if (addr[1:0] != 2'b00) begin
            r.rdata = 32'h0; r.err = 1'b1; exp_lat = 1;
        end else begin
            p.w = w; p.we = we; p.addr = addr; p.wdata = wdata;
            d_plan.push_back(p);
            r.err   = (w < 0);
            r.rdata = (w < 0 || we) ? 32'h0 : ref_rd(addr);
            if (we && w >= 0) ref_mem[addr] = wdata;
            exp_lat = (w < 0) ? TO + 1 : w + 2;
        end
        d_q.push_back(r);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (d_ready) break;
            lat++;
        end
        if (lat >= 60) chk("d_ready_timeout", 64'(lat), 64'(exp_lat));
        else if (solo) chk("d_latency", 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_req"}, 64'(m_req), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_readies"}, 64'({if_ready, d_ready}), 64'd0);
        chk({tag, "_errs"}, 64'({if_err, d_err}), 64'd0);
        chk({tag, "_m_we"}, 64'(m_we), 64'd0);
        chk({tag, "_m_addr"}, 64'(m_addr), 64'd0);
        chk({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    endtask

    // Backing memory: follows the ack plan, checks the request stays stable,
    // measures timeout length and injects a late ack after every abort.
    initial begin
        plan_t cur;
        bit    active;
        int    cnt;
        m_ack = 1'b0; m_rdata = 32'h0; active = 1'b0; cnt = 0;
        cur.w = 0; cur.we = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            m_ack = 1'b0;
            if (rst) begin
                active = 1'b0;
            end else if (m_req) begin
                if (!active) begin
                    active = 1'b1; cnt = 0;
                    if (m_addr < 32'h400 && if_plan.size() > 0) cur = if_plan.pop_front();
                    else if (m_addr >= 32'h400 && d_plan.size() > 0) cur = d_plan.pop_front();
                    else begin
                        chk("m_req_unplanned_addr", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                        cur.w = 0; cur.we = m_we; cur.addr = m_addr; cur.wdata = m_wdata;
                    end
                end
                chk("m_addr", 64'(m_addr), 64'(cur.addr));
                chk("m_we", 64'(m_we), 64'(cur.we));
                if (cur.we || cur.addr < 32'h400) chk("m_wdata", 64'(m_wdata), 64'(cur.wdata));
                cnt++;
                if (cur.w >= 0 && cnt == cur.w + 1) begin
                    m_ack = 1'b1;
                    if (cur.we) begin
                        bmem[cur.addr] = cur.wdata;
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = bmem_rd(cur.addr);
                    end
                end else if (cur.w >= 0 && cnt > cur.w + 1) begin
                    chk("m_req_after_ack", 64'(m_req), 64'd0);
                end
            end else if (active) begin
                active = 1'b0;
                if (cur.w < 0) begin
                    chk("timeout_m_req_cycles", 64'(cnt), 64'(TO));
                    m_ack = 1'b1;
                    m_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each ready pulse, checks data hold,
    // ready exclusivity and D-over-IF priority.
    initial begin
        resp_t       e;
        logic [31:0] if_last, d_last;
        bit          prio_pending;
        if_last = 32'h0; d_last = 32'h0; prio_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if_last = 32'h0; d_last = 32'h0; prio_pending = 1'b0;
            end else begin
                if (if_ready) begin
                    if (if_q.size() == 0) chk("if_ready_unexpected", 64'(if_ready), 64'd0);
                    else begin
                        e = if_q.pop_front();
                        chk("if_rdata", 64'(if_rdata), 64'(e.rdata));
                        chk("if_err", 64'(if_err), 64'(e.err));
                        if_last = e.rdata;
                    end
                end else begin
                    chk("if_rdata_hold", 64'(if_rdata), 64'(if_last));
                end
                if (d_ready) begin
                    if (d_q.size() == 0) chk("d_ready_unexpected", 64'(d_ready), 64'd0);
                    else begin
                        e = d_q.pop_front();
                        chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
                        chk("d_err", 64'(d_err), 64'(e.err));
                        d_last = e.rdata;
                    end
                end else begin
                    chk("d_rdata_hold", 64'(d_rdata), 64'(d_last));
                end
                chk("ready_exclusive", 64'(if_ready & d_ready), 64'd0);
                if (prio_pending) begin
                    chk("d_priority", 64'(d_ready | (m_req & (m_addr >= 32'h400))), 64'd1);
                    prio_pending = 1'b0;
                end
                if (!busy && d_req && if_req) prio_pending = 1'b1;
            end
        end
    end

    // Main stimulus: directed scenarios, reset abort, then randomized traffic.
    initial begin
        int          mode;
        int          wa, wb;
        logic [31:0] ia, da;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        ref_mem[32'h10] = 32'hE3A0_0014;
        bmem[32'h10]    = 32'hE3A0_0014;
        #1;
        check_reset_outputs("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_if(32'h10, 0, 1'b1);
        do_d(1'b1, 32'h400, 32'h2000, 3, 1'b1);
        do_d(1'b0, 32'h400, 32'h0, 1, 1'b1);
        fork
            do_if(32'h20, 1, 1'b0);
            do_d(1'b0, 32'h404, 32'h0, 1, 1'b0);
        join
        do_d(1'b0, 32'h40D, 32'h0, 0, 1'b1);
        do_if(32'h22, 0, 1'b1);
        do_d(1'b0, 32'h408, 32'h0, -1, 1'b1);
        do_if(32'h24, -1, 1'b1);
        do_if(32'h28, TO - 1, 1'b1);

        // Reset in the middle of a D access: no response, everything cleared.
        begin
            plan_t p;
            p.w = -1; p.we = 1'b0; p.addr = 32'h40C; p.wdata = 32'h0;
            d_plan.push_back(p);
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40C;
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check_reset_outputs("reset_mid_access");
            d_req = 1'b0;
            @(posedge clk);
            #2 rst = 1'b0;
        end
        do_if(32'h30, 2, 1'b1);

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 2);
            wa = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO - 1);
            wb = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO - 1);
            ia = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            da = 32'h400 | {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
            fork
                if (mode != 1) do_if(ia, wa, mode == 0);
                if (mode != 0) do_d(1'($urandom_range(0, 1)), da, $urandom, wb, mode == 1);
            join
        end

        for (int k = 0; k < 100 && (if_q.size() + d_q.size()) != 0; k++) @(posedge clk);
        chk("scoreboard_drained", 64'(if_q.size() + d_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
